// File: rtl/servo_pkg.sv
// Shared definitions for the servo ramp and PWM timebase blocks.
package servo_pkg;

    localparam int MS = 1_000_000;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HOLD = 3'd1,
        S_RAMP = 3'd2
    } state_t;

    function automatic int ms_cnt_w(input int clk_per_ns);
        int w;
        w = $clog2(1 + MS / clk_per_ns);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// ms / frame timebase: a registered ms tick and a frame pulse every FRAME_MS ms.
module tick_divider
    import servo_pkg::*;
#(
    parameter int CLK_PER_NS = 40,
    parameter int FRAME_MS   = 20
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic enable_i,
    output logic ms_tick_o,
    output logic frame_tick_o
);

    localparam int              MS_W     = ms_cnt_w(CLK_PER_NS);
    localparam logic [MS_W-1:0] MS_LAST  = MS_W'(MS / CLK_PER_NS);
    localparam int              FRM_W    = (FRAME_MS > 1) ? $clog2(FRAME_MS) : 1;
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FRAME_MS - 1);

    logic [MS_W-1:0]  mscnt;
    logic [FRM_W-1:0] frmcnt;
    logic             ms_tick;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mscnt   <= '0;
            ms_tick <= 1'b0;
        end else if (!enable_i) begin
            mscnt   <= '0;
            ms_tick <= 1'b0;
        end else if (mscnt == MS_LAST) begin
            mscnt   <= '0;
            ms_tick <= 1'b1;
        end else begin
            mscnt   <= mscnt + 1'b1;
            ms_tick <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            frmcnt <= '0;
        end else if (!enable_i) begin
            frmcnt <= '0;
        end else if (ms_tick) begin
            frmcnt <= (frmcnt == FRM_LAST) ? '0 : frmcnt + 1'b1;
        end
    end

    // The frame pulse coincides with the ms tick that wraps the frame counter.
    assign ms_tick_o    = ms_tick;
    assign frame_tick_o = ms_tick && (frmcnt == FRM_LAST);

endmodule

// File: rtl/servo_ramp.sv
// Slews position_o toward the accepted target by at most STEP codes per servo frame.
module servo_ramp
    import servo_pkg::*;
#(
    parameter int CLK_PER_NS = 40,
    parameter int N          = 8,
    parameter int FRAME_MS   = 20,
    parameter int STEP       = 1,
    parameter int INIT_POS   = 2**(N-1)
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         enable_i,
    input  logic         tgt_valid_i,
    input  logic [N-1:0] tgt_pos_i,
    output logic         tgt_ready_o,
    output logic [N-1:0] position_o,
    output logic         en_o,
    output logic         busy_o,
    output logic         frame_o
);

    localparam logic [N:0]   STEP_W = (N+1)'(STEP);
    localparam logic [N-1:0] INIT_Q = N'(INIT_POS);

    state_t       state, state_nx;
    logic [N-1:0] target_q;
    logic         xfer;
    logic         do_slew;
    logic         frame_tick;
    logic         ms_tick_unused;

    // One bounded step toward tgt in N+1 bits; clamping to the distance prevents overshoot and wrap.
    function automatic logic [N-1:0] slew(input logic [N-1:0] pos, input logic [N-1:0] tgt);
        logic [N:0] p, t, d;
        p = {1'b0, pos};
        t = {1'b0, tgt};
        if (t > p) begin
            d = t - p;
            p = p + ((d < STEP_W) ? d : STEP_W);
        end else if (t < p) begin
            d = p - t;
            p = p - ((d < STEP_W) ? d : STEP_W);
        end
        return N'(p);
    endfunction

    tick_divider #(
        .CLK_PER_NS (CLK_PER_NS),
        .FRAME_MS   (FRAME_MS)
    ) u_tick (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .enable_i     (enable_i),
        .ms_tick_o    (ms_tick_unused),
        .frame_tick_o (frame_tick)
    );

    assign xfer    = tgt_valid_i && tgt_ready_o;
    assign do_slew = frame_tick && enable_i && (state == S_RAMP);

    always_comb begin
        state_nx = state;
        if (!enable_i) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  state_nx = S_HOLD;
                S_HOLD:  if (target_q != position_o) state_nx = S_RAMP;
                S_RAMP:  if (target_q == position_o) state_nx = S_HOLD;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state       <= S_IDLE;
            en_o        <= 1'b0;
            tgt_ready_o <= 1'b0;
            position_o  <= INIT_Q;
            target_q    <= INIT_Q;
        end else begin
            state       <= state_nx;
            en_o        <= (state_nx != S_IDLE);
            tgt_ready_o <= (state_nx != S_IDLE);
            if (do_slew)
                position_o <= slew(position_o, target_q);
            // Re-enable adopts the current position so the servo does not jump.
            if (state == S_IDLE && enable_i)
                target_q <= position_o;
            else if (xfer)
                target_q <= tgt_pos_i;
        end
    end

    assign busy_o  = (state == S_RAMP);
    assign frame_o = frame_tick;

endmodule

// File: tb/tb_servo_ramp.sv
// Bench for servo_ramp: STEP=1 and STEP=10 instances, ms tick every 11 cycles, frame every 22.
`timescale 1ns/1ps
module tb_servo_ramp;

    localparam int CLK_NS = 100000;
    localparam int NB     = 8;
    localparam int FRM    = 2;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic       en1 = 1'b0, vld1 = 1'b0, en10 = 1'b0, vld10 = 1'b0;
    logic [7:0] tgt1 = 8'd0, tgt10 = 8'd0;
    logic       rdy1, rdy10, eno1, eno10, busy1, busy10, frm1, frm10;
    logic [7:0] pos1, pos10;

    always #5 clk = ~clk;

    servo_ramp #(.CLK_PER_NS(CLK_NS), .N(NB), .FRAME_MS(FRM), .STEP(1)) u_dut1 (
        .clk_i(clk), .rstn_i(rstn), .enable_i(en1), .tgt_valid_i(vld1), .tgt_pos_i(tgt1),
        .tgt_ready_o(rdy1), .position_o(pos1), .en_o(eno1), .busy_o(busy1), .frame_o(frm1));

    servo_ramp #(.CLK_PER_NS(CLK_NS), .N(NB), .FRAME_MS(FRM), .STEP(10)) u_dut10 (
        .clk_i(clk), .rstn_i(rstn), .enable_i(en10), .tgt_valid_i(vld10), .tgt_pos_i(tgt10),
        .tgt_ready_o(rdy10), .position_o(pos10), .en_o(eno10), .busy_o(busy10), .frame_o(frm10));

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] q1[$];
    logic [7:0] q10[$];
    int         m1 = 128, m10 = 128;
    logic [7:0] last1 = 8'd128, last10 = 8'd128;
    logic       pf1 = 1'b0, pf10 = 1'b0;
    int         ch10 = 0;

    typedef struct {
        int tgt;
        int exp_pos;
        int exp_moves;
    } vec_t;
    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Expected position after each frame step, from 'from' up/down to 'to'.
    function automatic void push_ramp(input int from, input int to, input int step, input bit ten);
        int p;
        p = from;
        while (p != to) begin
            if (to > p) p = (to - p > step) ? p + step : to;
            else        p = (p - to > step) ? p - step : to;
            if (ten) q10.push_back(8'(p));
            else     q1.push_back(8'(p));
        end
    endfunction

    // Scoreboard: every position change must follow a frame pulse and match the queued value.
    always @(negedge clk) begin
        if (rstn && pos1 != last1) begin
            check("pos1_after_frame", int'(pf1), 1);
            if (q1.size() == 0) check("pos1_unexpected_move", int'(pos1), int'(last1));
            else                check("pos1_step", int'(pos1), int'(q1.pop_front()));
        end
        if (rstn && pos10 != last10) begin
            ch10++;
            check("pos10_after_frame", int'(pf10), 1);
            if (q10.size() == 0) check("pos10_unexpected_move", int'(pos10), int'(last10));
            else                 check("pos10_step", int'(pos10), int'(q10.pop_front()));
        end
        last1  = pos1;
        last10 = pos10;
        pf1    = frm1;
        pf10   = frm10;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_frame(input bit ten, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(ten ? frm10 : frm1) && n < 200);
        if (!(ten ? frm10 : frm1)) check("frame_timeout", 0, 1);
    endtask

    task automatic wait_pos(input bit ten, input int v, input int budget);
        int n;
        n = 0;
        while (int'(ten ? pos10 : pos1) != v && n < budget) begin
            tick();
            n++;
        end
        check("reach_pos", int'(ten ? pos10 : pos1), v);
    endtask

    task automatic send(input bit ten, input int v);
        if (ten) begin
            check("ready10_at_send", int'(rdy10), 1);
            vld10 = 1'b1; tgt10 = 8'(v);
            push_ramp(m10, v, 10, 1'b1);
            m10 = v;
        end else begin
            check("ready1_at_send", int'(rdy1), 1);
            vld1 = 1'b1; tgt1 = 8'(v);
            push_ramp(m1, v, 1, 1'b0);
            m1 = v;
        end
        tick();
        vld1  = 1'b0;
        vld10 = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        vecs[0] = '{255, 255, 13};
        vecs[1] = '{250, 250, 1};
        vecs[2] = '{0,   0,   25};
        vecs[3] = '{0,   0,   0};
        vecs[4] = '{7,   7,   1};
        vecs[5] = '{255, 255, 25};
        vecs[6] = '{0,   0,   26};

        // Reset values and enable
        repeat (3) tick();
        check("rst_pos1", int'(pos1), 128);
        check("rst_pos10", int'(pos10), 128);
        check("rst_en1", int'(eno1), 0);
        check("rst_rdy1", int'(rdy1), 0);
        check("rst_busy1", int'(busy1), 0);
        check("rst_frame1", int'(frm1), 0);
        rstn = 1'b1;
        tick();
        check("idle_en1", int'(eno1), 0);
        en1 = 1'b1; en10 = 1'b1;
        tick();
        check("en1_rise", int'(eno1), 1);
        check("rdy1_rise", int'(rdy1), 1);
        check("en10_rise", int'(eno10), 1);
        check("busy1_hold", int'(busy1), 0);
        wait_frame(1'b0, n);
        check("first_frame_cycles", n, 21);
        check("frm10_aligned", int'(frm10), 1);
        wait_frame(1'b0, n);
        check("frame_period", n, 22);
        check("pos1_hold", int'(pos1), 128);

        // STEP=10 table: saturation at 255 and 0, no-op target
        for (int i = 0; i < 7; i++) begin
            ch10 = 0;
            send(1'b1, vecs[i].tgt);
            tick(); tick();
            n = 0;
            while (busy10 && n < 900) begin
                tick();
                n++;
            end
            check("vec_busy_done", int'(busy10), 0);
            check("vec_pos", int'(pos10), vecs[i].exp_pos);
            check("vec_moves", ch10, vecs[i].exp_moves);
        end

        // STEP=1 ramp to 131
        send(1'b0, 131);
        tick();
        check("busy1_rise", int'(busy1), 1);
        wait_pos(1'b0, 131, 5 * 22);
        check("busy1_at_reach", int'(busy1), 1);
        tick();
        check("busy1_fall", int'(busy1), 0);

        // Transfer landing on a frame cycle uses the old target for that frame
        send(1'b0, 140);
        wait_pos(1'b0, 135, 6 * 22);
        wait_frame(1'b0, n);
        check("ready1_on_frame", int'(rdy1), 1);
        vld1 = 1'b1; tgt1 = 8'd200;
        q1.delete();
        q1.push_back(8'd136);
        push_ramp(136, 200, 1, 1'b0);
        m1 = 200;
        tick();
        vld1 = 1'b0;
        check("same_frame_slew", int'(pos1), 136);
        wait_pos(1'b0, 137, 30);

        // Disable mid-ramp, offer a target while not ready, re-enable
        wait_pos(1'b0, 150, 16 * 22);
        en1 = 1'b0;
        q1.delete();
        m1 = 150;
        tick();
        check("dis_en1", int'(eno1), 0);
        check("dis_rdy1", int'(rdy1), 0);
        check("dis_busy1", int'(busy1), 0);
        vld1 = 1'b1; tgt1 = 8'd10;
        repeat (5) tick();
        vld1 = 1'b0;
        repeat (60) tick();
        check("dis_pos1", int'(pos1), 150);
        en1 = 1'b1;
        tick();
        check("reen_en1", int'(eno1), 1);
        check("reen_rdy1", int'(rdy1), 1);
        repeat (60) tick();
        check("reen_busy1", int'(busy1), 0);
        check("reen_pos1", int'(pos1), 150);

        // Asynchronous reset mid-ramp
        send(1'b0, 180);
        wait_pos(1'b0, 153, 5 * 22);
        #2;
        rstn = 1'b0;
        q1.delete();
        q10.delete();
        m1 = 128; m10 = 128;
        #1;
        check("arst_pos1", int'(pos1), 128);
        check("arst_en1", int'(eno1), 0);
        check("arst_rdy1", int'(rdy1), 0);
        check("arst_busy1", int'(busy1), 0);
        check("arst_frame1", int'(frm1), 0);
        check("arst_pos10", int'(pos10), 128);
        repeat (3) tick();
        rstn = 1'b1;
        repeat (60) tick();
        check("post_rst_en1", int'(eno1), 1);
        check("post_rst_pos1", int'(pos1), 128);
        check("post_rst_busy1", int'(busy1), 0);
        check("q1_drained", q1.size(), 0);
        check("q10_drained", q10.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
